// File: rtl/calc_pkg.sv
// Shared command codes, keypad FSM state type and key-to-command encoding
// for the calculator keypad front end.
package calc_pkg;

  localparam logic [3:0] CMD_0    = 4'b0000;
  localparam logic [3:0] CMD_1    = 4'b0001;
  localparam logic [3:0] CMD_2    = 4'b0010;
  localparam logic [3:0] CMD_3    = 4'b0011;
  localparam logic [3:0] CMD_4    = 4'b0100;
  localparam logic [3:0] CMD_5    = 4'b0101;
  localparam logic [3:0] CMD_6    = 4'b0110;
  localparam logic [3:0] CMD_7    = 4'b0111;
  localparam logic [3:0] CMD_8    = 4'b1000;
  localparam logic [3:0] CMD_9    = 4'b1001;
  localparam logic [3:0] CMD_ADD  = 4'b1010;
  localparam logic [3:0] CMD_SUB  = 4'b1011;
  localparam logic [3:0] CMD_MUL  = 4'b1100;
  localparam logic [3:0] CMD_CLR  = 4'b1101;
  localparam logic [3:0] CMD_EQ   = 4'b1110;
  localparam logic [3:0] CMD_IDLE = 4'b1111;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} kp_state_t;

  // Reserved position (r3,c3) maps to CMD_IDLE, which callers treat as "no emission".
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = CMD_1;
      4'h1:    code = CMD_2;
      4'h2:    code = CMD_3;
      4'h3:    code = CMD_ADD;
      4'h4:    code = CMD_4;
      4'h5:    code = CMD_5;
      4'h6:    code = CMD_6;
      4'h7:    code = CMD_SUB;
      4'h8:    code = CMD_7;
      4'h9:    code = CMD_8;
      4'hA:    code = CMD_9;
      4'hB:    code = CMD_MUL;
      4'hC:    code = CMD_CLR;
      4'hD:    code = CMD_0;
      4'hE:    code = CMD_EQ;
      default: code = CMD_IDLE;
    endcase
    return code;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_index(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every SCAN_DIV clocks;
// the tick marks the last cycle of a keypad column slot.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(SCAN_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_cmd_encoder.sv
// 4x4 active-low keypad scanner/debouncer emitting one cmd strobe per press.
// Optional auto-repeat of a held key is built when KEY_REPEAT_EN is defined.
module keypad_cmd_encoder
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_CNT   = 4,
  parameter logic [3:0]  IDLE_CMD       = CMD_IDLE,
  parameter int unsigned REPEAT_SAMPLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] cmd,
  output logic       cmd_valid
);

  localparam int unsigned DCW = $clog2(DEBOUNCE_CNT + 1);

  logic       tick;
  logic [3:0] row_low;
  logic       one_row;
  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic       match;
  logic       reserved;
  logic [3:0] code;
  logic       rep_fire;

  kp_state_t      state_q, state_d;
  logic [3:0]     col_q, col_d;
  logic [1:0]     row_q, row_d;
  logic [DCW-1:0] cnt_q, cnt_d;
  logic [3:0]     cmd_q, cmd_d;
  logic           valid_q, valid_d;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  assign row_low  = ~row_in;
  assign one_row  = is_onehot(row_low);
  assign row_idx  = onehot_index(row_low);
  assign col_idx  = onehot_index(~col_q);
  assign match    = one_row && (row_idx == row_q);
  assign code     = key_code(row_q, col_idx);
  assign reserved = (code == CMD_IDLE);

`ifdef KEY_REPEAT_EN
  localparam int unsigned RCW = $clog2(REPEAT_SAMPLES + 1);

  logic [RCW-1:0] rep_q, rep_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end

  // Hold count only advances on samples that still show the latched key.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (state_q != WAIT_RELEASE) begin
      rep_d = '0;
    end else if (tick) begin
      if (!match || reserved) begin
        rep_d = '0;
      end else if (rep_q >= RCW'(REPEAT_SAMPLES - 1)) begin
        rep_d    = '0;
        rep_fire = 1'b1;
      end else begin
        rep_d = rep_q + RCW'(1);
      end
    end
  end
`else
  // Parameter kept for interface compatibility; nothing consumes it in this build.
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_SAMPLES;
  assign rep_fire      = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SCAN;
      col_q   <= 4'b1110;
      row_q   <= '0;
      cnt_q   <= '0;
      cmd_q   <= IDLE_CMD;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SCAN: begin
        if (tick) begin
          if (one_row) begin
            row_d   = row_idx;
            cnt_d   = DCW'(1);
            state_d = DEBOUNCE;
          end else begin
            // No key or a ghosting multi-row pattern: move on to the next column.
            col_d = {col_q[2:0], col_q[3]};
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (!match) begin
            cnt_d   = '0;
            state_d = SCAN;
          end else if (cnt_q >= DCW'(DEBOUNCE_CNT - 1)) begin
            cnt_d   = '0;
            state_d = reserved ? WAIT_RELEASE : EMIT;
          end else begin
            cnt_d = cnt_q + DCW'(1);
          end
        end
      end
      EMIT: begin
        cnt_d   = '0;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (tick) begin
          if (row_low != 4'd0) begin
            cnt_d = '0;
          end else if (cnt_q >= DCW'(DEBOUNCE_CNT - 1)) begin
            cnt_d   = '0;
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + DCW'(1);
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Strobe is registered so it is visible exactly while the FSM sits in EMIT.
  always_comb begin
    cmd_d   = IDLE_CMD;
    valid_d = 1'b0;
    if (((state_q == DEBOUNCE) && (state_d == EMIT)) || rep_fire) begin
      cmd_d   = code;
      valid_d = 1'b1;
    end
  end

  assign col_out   = col_q;
  assign cmd       = cmd_q;
  assign cmd_valid = valid_q;

endmodule

// File: tb/tb_keypad_cmd_encoder.sv
// Self-checking bench for keypad_cmd_encoder: keypad matrix model, strobe monitor
// and an arithmetic key-code reference model.
module tb_keypad_cmd_encoder;

  localparam int unsigned SCAN_DIV       = 4;
  localparam int unsigned DEBOUNCE_CNT   = 2;
  localparam int unsigned REPEAT_SAMPLES = 3;
  localparam int          MAX_LAT        = (4 + DEBOUNCE_CNT) * SCAN_DIV + 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] cmd;
  logic       cmd_valid;

  logic [3:0] pr [4];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         idle_bad = 0;
  bit         mon_en = 1'b0;
  logic [3:0] strobes [$];
  int         strobe_cyc [$];

  keypad_cmd_encoder #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_CNT  (DEBOUNCE_CNT),
    .IDLE_CMD      (4'b1111),
    .REPEAT_SAMPLES(REPEAT_SAMPLES)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .cmd      (cmd),
    .cmd_valid(cmd_valid)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pr[r][c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      if (cmd_valid === 1'b1) begin
        strobes.push_back(cmd);
        strobe_cyc.push_back(cyc);
      end else if (cmd !== 4'hF) begin
        idle_bad <= idle_bad + 1;
      end
    end
  end

  // Key code from the keypad legend; -1 marks the reserved key.
  function automatic int ref_code(input int r, input int c);
    if (c == 3) return (r == 3) ? -1 : 10 + r;
    if (r < 3) return 3 * r + c + 1;
    if (c == 1) return 0;
    return (c == 0) ? 13 : 14;
  endfunction

  task automatic release_all();
    for (int r = 0; r < 4; r++) pr[r] = 4'h0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && strobes.size() < n; i++) tick_n(1);
    ok = (strobes.size() >= n);
  endtask

  task automatic count_changes(input int n, output int changes);
    logic [3:0] prev;
    changes = 0;
    prev    = col_out;
    for (int i = 0; i < n; i++) begin
      tick_n(1);
      if (col_out !== prev) changes++;
      prev = col_out;
    end
  endtask

  task automatic test_reset();
    logic [3:0] prev;
    logic [3:0] exp;
    int         steps;
    release_all();
    #1 reset = 1'b1;
    tick_n(2);
    checks++;
    if (col_out !== 4'b1110) begin
      errors++; $display("FAIL reset_col: got %b expected 1110", col_out);
    end
    checks++;
    if (cmd !== 4'b1111) begin
      errors++; $display("FAIL reset_cmd: got %b expected 1111", cmd);
    end
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", cmd_valid);
    end
    mon_en = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    for (int k = 1; k <= 4; k++) begin
      prev  = col_out;
      steps = 0;
      while (col_out === prev && steps < 3 * SCAN_DIV) begin
        tick_n(1);
        steps++;
      end
      exp = ~(4'b0001 << (k % 4));
      checks++;
      if (col_out !== exp || steps != SCAN_DIV) begin
        errors++;
        $display("FAIL rotate_%0d: got col=%b after %0d cycles expected col=%b after %0d",
                 k, col_out, steps, exp, SCAN_DIV);
      end
    end
  endtask

  task automatic test_hold_key();
    int n0, start, changes;
    bit ok;
    n0    = strobes.size();
    start = cyc;
    pr[0][2] = 1'b1;
    wait_strobes(n0 + 1, MAX_LAT + 2, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL hold_strobe: got %0d strobes expected 1", strobes.size() - n0);
    end else begin
      checks++;
      if (strobes[n0] !== 4'(ref_code(0, 2))) begin
        errors++; $display("FAIL hold_code: got %b expected %b", strobes[n0], 4'(ref_code(0, 2)));
      end
      checks++;
      if (strobe_cyc[n0] - start > MAX_LAT) begin
        errors++;
        $display("FAIL hold_latency: got %0d cycles expected <= %0d", strobe_cyc[n0] - start, MAX_LAT);
      end
    end
`ifdef KEY_REPEAT_EN
    tick_n(8);
`else
    tick_n(60);
`endif
    checks++;
    if (strobes.size() != n0 + 1) begin
      errors++; $display("FAIL hold_single: got %0d strobes expected 1", strobes.size() - n0);
    end
    release_all();
    count_changes(30, changes);
    checks++;
    if (changes < 4) begin
      errors++; $display("FAIL hold_resume: got %0d column changes expected >= 4", changes);
    end
  endtask

  task automatic test_bounce();
    int n0;
    n0 = strobes.size();
    for (int i = 0; i < 40; i++) begin
      pr[1][1] = ~pr[1][1];
      tick_n(3);
    end
    release_all();
    tick_n(20);
    checks++;
    if (strobes.size() != n0) begin
      errors++; $display("FAIL bounce: got %0d strobes expected 0", strobes.size() - n0);
    end
  endtask

  task automatic test_ghost();
    int n0, changes;
    n0 = strobes.size();
    pr[0][0] = 1'b1;
    pr[1][0] = 1'b1;
    count_changes(40, changes);
    checks++;
    if (changes < 8) begin
      errors++; $display("FAIL ghost_scan: got %0d column changes expected >= 8", changes);
    end
    checks++;
    if (strobes.size() != n0) begin
      errors++; $display("FAIL ghost_strobe: got %0d strobes expected 0", strobes.size() - n0);
    end
    release_all();
    tick_n(12);
  endtask

  task automatic test_sequence();
    int         kr [$];
    int         kc [$];
    logic [3:0] expq [$];
    int         n0, n_start, start, code, k;
    bit         ok;
    kr = '{0, 0, 0, 3};
    kc = '{2, 3, 0, 2};
    for (int i = 0; i < 6; i++) begin
      k = $urandom_range(0, 15);
      kr.push_back(k / 4);
      kc.push_back(k % 4);
    end
    n_start = strobes.size();
    idle_bad = 0;
    for (int i = 0; i < kr.size(); i++) begin
      n0    = strobes.size();
      start = cyc;
      code  = ref_code(kr[i], kc[i]);
      pr[kr[i]][kc[i]] = 1'b1;
      if (code >= 0) begin
        expq.push_back(4'(code));
        wait_strobes(n0 + 1, MAX_LAT + 2, ok);
        checks++;
        if (!ok || strobe_cyc[n0] - start > MAX_LAT) begin
          errors++;
          $display("FAIL seq_latency_%0d: got %0d strobes after %0d cycles expected 1 within %0d",
                   i, strobes.size() - n0, cyc - start, MAX_LAT);
        end
        tick_n($urandom_range(1, 6));
      end else begin
        tick_n(40);
      end
      release_all();
      tick_n($urandom_range(24, 40));
    end
    checks++;
    if (strobes.size() - n_start != expq.size()) begin
      errors++;
      $display("FAIL seq_count: got %0d strobes expected %0d", strobes.size() - n_start, expq.size());
    end
    for (int i = 0; i < expq.size() && n_start + i < strobes.size(); i++) begin
      checks++;
      if (strobes[n_start + i] !== expq[i]) begin
        errors++;
        $display("FAIL seq_code_%0d: got %b expected %b", i, strobes[n_start + i], expq[i]);
      end
    end
    checks++;
    if (idle_bad != 0) begin
      errors++; $display("FAIL seq_idle: got %0d non-idle cycles expected 0", idle_bad);
    end
  endtask

  task automatic test_reset_mid();
    int n0, steps;
    release_all();
    steps = 0;
    while (col_out !== 4'b1110 && steps < 20) begin
      tick_n(1);
      steps++;
    end
    n0 = strobes.size();
    pr[2][3] = 1'b1;
    steps = 0;
    while (col_out !== 4'b0111 && steps < 20) begin
      tick_n(1);
      steps++;
    end
    tick_n(5);
    checks++;
    if (col_out !== 4'b0111) begin
      errors++; $display("FAIL mid_frozen: got col=%b expected 0111", col_out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (col_out !== 4'b1110 || cmd !== 4'b1111 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got col=%b cmd=%b valid=%b expected 1110 1111 0",
               col_out, cmd, cmd_valid);
    end
    tick_n(3);
    release_all();
    reset = 1'b0;
    tick_n(40);
    checks++;
    if (strobes.size() != n0) begin
      errors++; $display("FAIL mid_strobe: got %0d strobes expected 0", strobes.size() - n0);
    end
  endtask

  task automatic test_repeat();
    int n0;
    bit ok;
    n0 = strobes.size();
    pr[2][2] = 1'b1;
    wait_strobes(n0 + 1, MAX_LAT + 2, ok);
    tick_n(38);
    release_all();
    tick_n(20);
    checks++;
    if (strobes.size() != n0 + 4) begin
      errors++; $display("FAIL repeat_count: got %0d strobes expected 4", strobes.size() - n0);
    end
    for (int i = n0; i < strobes.size(); i++) begin
      checks++;
      if (strobes[i] !== 4'(ref_code(2, 2))) begin
        errors++; $display("FAIL repeat_code_%0d: got %b expected 1001", i - n0, strobes[i]);
      end
      if (i > n0) begin
        checks++;
        if (strobe_cyc[i] - strobe_cyc[i-1] != int'(REPEAT_SAMPLES * SCAN_DIV)) begin
          errors++;
          $display("FAIL repeat_gap_%0d: got %0d cycles expected %0d", i - n0,
                   strobe_cyc[i] - strobe_cyc[i-1], REPEAT_SAMPLES * SCAN_DIV);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hold_key();
    test_bounce();
    test_ghost();
    test_sequence();
    test_reset_mid();
`ifdef KEY_REPEAT_EN
    test_repeat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
